// File: rtl/rtx_fb_writer.sv
// rtl/rtx_fb_writer.sv - RGB565 framebuffer writer with elastic output FIFO
//
// Packs finished tracer pixels to RGB565, computes the linear framebuffer
// address, queues them in a show-ahead FIFO and drains it into a
// backpressured framebuffer write port. It flags frame completion, counts
// frames and latches a sticky overflow when a pixel is lost to a full FIFO.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pixel_valid      one-cycle pixel strobe, qualifies pixel_rgb/pixel_h/pixel_v
//   pixel_rgb        [0]=red [1]=green [2]=blue, 8 bits each
//   pixel_h/pixel_v  screen column / row
//   fb_we            write request, high while the FIFO holds an entry
//   fb_addr/fb_data  address and RGB565 word of the FIFO head
//   fb_ready         framebuffer accepts the write this cycle
//   frame_done       one-cycle pulse after the frame's last pixel is written
//   frame_count      completed frames, wraps at 256
//   overflow         sticky: a pixel was dropped because the FIFO was full
//   fifo_level       current FIFO occupancy
module rtx_fb_writer #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pixel_valid,
  input  logic [2:0][7:0]             pixel_rgb,
  input  logic [10:0]                 pixel_h,
  input  logic [9:0]                  pixel_v,
  output logic                        fb_we,
  output logic [ADDR_WIDTH-1:0]       fb_addr,
  output logic [15:0]                 fb_data,
  input  logic                        fb_ready,
  output logic                        frame_done,
  output logic [7:0]                  frame_count,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] W32 = 32'(WIDTH);
  localparam logic [31:0] H32 = 32'(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] WIDTH_A = ADDR_WIDTH'(WIDTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  // Stage S1: packed pixel register
  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [15:0]           s1_data_q;
  logic                  s1_last_q;

  logic [31:0] h_ext;
  logic [31:0] v_ext;
  logic        in_range;
  logic        take;

  assign h_ext    = {21'd0, pixel_h};
  assign v_ext    = {22'd0, pixel_v};
  assign in_range = (h_ext < W32) && (v_ext < H32);
  assign take     = pixel_valid && in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= take;
      if (take) begin
        s1_addr_q <= ADDR_WIDTH'(pixel_v) * WIDTH_A + ADDR_WIDTH'(pixel_h);
        s1_data_q <= {pixel_rgb[0][7:3], pixel_rgb[1][7:2], pixel_rgb[2][7:3]};
        s1_last_q <= (h_ext == W32 - 32'd1) && (v_ext == H32 - 32'd1);
      end
    end
  end

  // Stage S2: show-ahead FIFO
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [15:0]           mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          empty, full, push, pop, drop, head_last;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = !empty && fb_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push  = s1_valid_q && (!full || pop);
  assign drop  = s1_valid_q && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= s1_addr_q;
      mem_data[wr_ptr_q] <= s1_data_q;
      mem_last[wr_ptr_q] <= s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Head outputs read as zero when empty so the port idles at 0.
  assign fb_we     = !empty;
  assign fb_addr   = empty ? '0 : mem_addr[rd_ptr_q];
  assign fb_data   = empty ? '0 : mem_data[rd_ptr_q];
  assign head_last = mem_last[rd_ptr_q];

  // Frame tracking and overflow
  logic       frame_done_q;
  logic [7:0] frame_count_q;
  logic       overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      overflow_q    <= 1'b0;
    end else begin
      frame_done_q <= pop && head_last;
      if (pop && head_last) frame_count_q <= frame_count_q + 8'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign fifo_level  = count_q;

endmodule

// File: tb/tb_rtx_fb_writer.sv
// tb/tb_rtx_fb_writer.sv - directed self-checking bench for rtx_fb_writer
//
// Two instances: the default 1280x720 writer, and a 4x2 writer used to roll
// the frame counter through a full wrap. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_rtx_fb_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            pixel_valid;
  logic [2:0][7:0] pixel_rgb;
  logic [10:0]     pixel_h;
  logic [9:0]      pixel_v;
  logic            fb_we;
  logic [19:0]     fb_addr;
  logic [15:0]     fb_data;
  logic            fb_ready;
  logic            frame_done;
  logic [7:0]      frame_count;
  logic            overflow;
  logic [2:0]      fifo_level;

  logic            s_valid;
  logic [2:0][7:0] s_rgb;
  logic [10:0]     s_h;
  logic [9:0]      s_v;
  logic            s_we;
  logic [2:0]      s_addr;
  logic [15:0]     s_data;
  logic            s_done;
  logic [7:0]      s_count;
  logic            s_ovf;
  logic [1:0]      s_level;

  int n_cmp = 0;
  int n_bad = 0;

  rtx_fb_writer dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
    .pixel_h(pixel_h), .pixel_v(pixel_v), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_ready(fb_ready), .frame_done(frame_done),
    .frame_count(frame_count), .overflow(overflow), .fifo_level(fifo_level)
  );

  rtx_fb_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_WIDTH(3), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .rst(rst), .pixel_valid(s_valid), .pixel_rgb(s_rgb),
    .pixel_h(s_h), .pixel_v(s_v), .fb_we(s_we), .fb_addr(s_addr),
    .fb_data(s_data), .fb_ready(1'b1), .frame_done(s_done),
    .frame_count(s_count), .overflow(s_ovf), .fifo_level(s_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b);
    pixel_valid  = 1'b1;
    pixel_h      = 11'(h);
    pixel_v      = 10'(v);
    pixel_rgb[0] = r;
    pixel_rgb[1] = g;
    pixel_rgb[2] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", fb_we); end
    n_cmp++; if (fb_addr !== 20'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", fb_addr); end
    n_cmp++; if (fb_data !== 16'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", fb_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", frame_done); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", frame_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    fb_ready = 1'b1;
    drive(3, 2, 8'hFF, 8'h80, 8'h08);
    step();
    pixel_valid = 1'b0;
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL single_we_early got %b want 0", fb_we); end
    step();
    n_cmp++; if (fb_we !== 1'b1) begin n_bad++; $display("FAIL single_we got %b want 1", fb_we); end
    n_cmp++; if (fb_addr !== 20'd2563) begin n_bad++; $display("FAIL single_addr got %0d want 2563", fb_addr); end
    n_cmp++; if (fb_data !== 16'hFC01) begin n_bad++; $display("FAIL single_data got %h want fc01", fb_data); end
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL single_we_after got %b want 0", fb_we); end
  endtask

  task automatic test_overflow();
    int n;
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(10 + i, 5, 8'h00, 8'h00, 8'(i * 8));
      step();
    end
    pixel_valid = 1'b0;
    step();
    step();
    n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (fb_addr !== 20'd6410) begin n_bad++; $display("FAIL ovf_hold_addr got %0d want 6410", fb_addr); end
    n_cmp++; if (fb_data !== 16'd0) begin n_bad++; $display("FAIL ovf_hold_data got %h want 0", fb_data); end
    fb_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (fb_we) begin
        n_cmp++; if (fb_addr !== 20'(6410 + n)) begin n_bad++; $display("FAIL ovf_order_addr got %0d want %0d", fb_addr, 6410 + n); end
        n_cmp++; if (fb_data !== 16'(n)) begin n_bad++; $display("FAIL ovf_order_data got %h want %h", fb_data, n); end
        n++;
      end
      step();
    end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL ovf_writes got %0d want 4", n); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    fb_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i >= 5) begin
        fb_ready = 1'b1;
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL b2b_level got %0d want 4", fifo_level); end
        n_cmp++; if (fb_addr !== 20'(100 + i - 5)) begin n_bad++; $display("FAIL b2b_head got %0d want %0d", fb_addr, 100 + i - 5); end
      end
      drive(100 + i, 0, 8'h00, 8'h00, 8'h00);
      step();
    end
    pixel_valid = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL b2b_drain got %0d want 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got %b want 0", overflow); end
  endtask

  task automatic test_frame_end();
    fb_ready = 1'b1;
    drive(1279, 719, 8'h00, 8'h00, 8'h00);
    step();
    pixel_valid = 1'b0;
    step();
    n_cmp++; if (fb_we !== 1'b1) begin n_bad++; $display("FAIL last_we got %b want 1", fb_we); end
    n_cmp++; if (fb_addr !== 20'd921599) begin n_bad++; $display("FAIL last_addr got %0d want 921599", fb_addr); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL last_done_early got %b want 0", frame_done); end
    step();
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL last_done got %b want 1", frame_done); end
    n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL last_count got %0d want 1", frame_count); end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL last_done_pulse got %b want 0", frame_done); end
    drive(1280, 0, 8'hFF, 8'hFF, 8'hFF);
    step();
    drive(0, 720, 8'hFF, 8'hFF, 8'hFF);
    step();
    pixel_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL oor_we got %b want 0", fb_we); end
      step();
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL oor_ovf got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 8'd1) begin n_bad++; $display("FAIL oor_count got %0d want 1", frame_count); end
  endtask

  task automatic test_mid_reset();
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(20 + i, 3, 8'h11, 8'h22, 8'h33);
      step();
    end
    pixel_valid = 1'b0;
    step();
    step();
    n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL mr_pre_level got %0d want 3", fifo_level); end
    rst = 1'b1;
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL mr_we got %b want 0", fb_we); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL mr_level got %0d want 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mr_ovf got %b want 0", overflow); end
    n_cmp++; if (frame_count !== 8'd0) begin n_bad++; $display("FAIL mr_count got %0d want 0", frame_count); end
    rst = 1'b0;
    fb_ready = 1'b1;
    drive(7, 1, 8'h08, 8'h04, 8'h10);
    step();
    pixel_valid = 1'b0;
    step();
    n_cmp++; if (fb_we !== 1'b1) begin n_bad++; $display("FAIL mr_post_we got %b want 1", fb_we); end
    n_cmp++; if (fb_addr !== 20'd1287) begin n_bad++; $display("FAIL mr_post_addr got %0d want 1287", fb_addr); end
    n_cmp++; if (fb_data !== 16'h0822) begin n_bad++; $display("FAIL mr_post_data got %h want 0822", fb_data); end
  endtask

  task automatic test_frame_wrap();
    int pulses;
    pulses = 0;
    s_rgb = '0;
    for (int i = 0; i < 2048; i++) begin
      s_valid = 1'b1;
      s_h = 11'(i % 4);
      s_v = 10'((i / 4) % 2);
      step();
      if (s_done) pulses++;
    end
    s_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_done) pulses++;
    end
    n_cmp++; if (pulses !== 256) begin n_bad++; $display("FAIL wrap_pulses got %0d want 256", pulses); end
    n_cmp++; if (s_count !== 8'd0) begin n_bad++; $display("FAIL wrap_count got %0d want 0", s_count); end
    n_cmp++; if (s_ovf !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf got %b want 0", s_ovf); end
    n_cmp++; if (s_level !== 2'd0) begin n_bad++; $display("FAIL wrap_level got %0d want 0", s_level); end
  endtask

  initial begin
    rst = 1'b1;
    pixel_valid = 1'b0;
    pixel_rgb = '0;
    pixel_h = '0;
    pixel_v = '0;
    fb_ready = 1'b0;
    s_valid = 1'b0;
    s_rgb = '0;
    s_h = '0;
    s_v = '0;
    #1;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_frame_end();
    test_mid_reset();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtx_fb_writer.md
# rtx_fb_writer

Downstream stage of the ray-tracing core. Consumes finished pixels (8-bit RGB plus screen coordinates) as they leave the tracer, packs them to RGB565, computes the linear framebuffer address, and writes them through a small elastic FIFO into a framebuffer write port that can apply backpressure. It also flags frame completion, counts frames, and reports dropped pixels.

## Interface

Parameters:
- WIDTH, 1280, frame width in pixels
- HEIGHT, 720, frame height in pixels
- ADDR_WIDTH, 20, framebuffer address width; must satisfy WIDTH*HEIGHT <= 2^ADDR_WIDTH
- FIFO_DEPTH, 4, entries in the output FIFO; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pixel_valid  in  1  one-cycle strobe; pixel_rgb, pixel_h and pixel_v are valid in the same cycle
- pixel_rgb  in  [2:0][7:0]  index 0 = red, 1 = green, 2 = blue, unsigned 8-bit
- pixel_h  in  11  column, 0..WIDTH-1
- pixel_v  in  10  row, 0..HEIGHT-1
- fb_we  out  1  write request; high whenever the FIFO is non-empty
- fb_addr  out  ADDR_WIDTH  pixel_v*WIDTH + pixel_h of the FIFO head
- fb_data  out  16  RGB565 of the FIFO head: {r[7:3], g[7:2], b[7:3]}
- fb_ready  in  1  write accepted on a cycle where fb_we && fb_ready
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
- frame_count  out  8  completed frames, wraps 255 -> 0
- overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation

- Stage S1 (registered): on pixel_valid, register the 565 word, the address (pixel_v*WIDTH + pixel_h, computed in ADDR_WIDTH bits; the multiply may be by constant), a last flag (pixel_h==WIDTH-1 && pixel_v==HEIGHT-1), and s1_valid.
- Out-of-range coordinates (pixel_h >= WIDTH or pixel_v >= HEIGHT): s1_valid stays 0 and the pixel is discarded silently; overflow is not set.
- Stage S2: on s1_valid, push {addr, data, last} into the FIFO.
  - FIFO not full: push.
  - FIFO full with a pop in the same cycle: push accepted, level unchanged.
  - FIFO full with no pop: entry dropped, overflow <= 1 (held until rst).
- Output: show-ahead FIFO; fb_we = !empty; fb_addr/fb_data/head-last are driven from the head entry. Pop on fb_we && fb_ready. While fb_we && !fb_ready, fb_addr and fb_data are held stable.
- Pop of an entry with last=1: next cycle frame_done=1 for exactly one cycle, and frame_count increments on the same edge.
- Entries leave in arrival order; no reordering and no coalescing of duplicate addresses.

## Timing

- Reset values: fb_we=0, fb_addr=0, fb_data=0, frame_done=0, frame_count=0, overflow=0, fifo_level=0; S1 and the FIFO are emptied.
- rst asserted mid-operation discards all queued pixels; fb_we is 0 in the cycle after the rst edge.
- Latency: pixel_valid high in cycle N -> S1 valid in N+1 -> FIFO write at the end of N+1 -> fb_we=1 in N+2 if the FIFO was empty.
- Throughput: one pixel per cycle sustained while fb_ready=1.
- fifo_level updates on the edge of each push or pop; simultaneous push and pop leave it unchanged.
- frame_done is registered and does not depend combinationally on fb_ready.

## Test plan

- Single pixel h=3, v=2, rgb=(0xFF,0x80,0x08), fb_ready=1: fb_we high 2 cycles later for one cycle, fb_addr=2563, fb_data=0xFC01.
- fb_ready=0, 5 back-to-back valid pixels: fifo_level=4, overflow=1, outputs hold the first pixel. Then fb_ready=1: exactly 4 writes in input order, and overflow stays 1.
- Full FIFO with fb_ready=1 and continuous input: no drops, fifo_level constant, overflow stays 0.
- Pixel h=1279, v=719, rgb=(0,0,0): fb_addr=921599. One cycle after acceptance, frame_done pulses once and frame_count=1. Input pixel_h=1280: no write, no overflow.
- Reset with 3 entries queued and fb_ready=0: next cycle fb_we=0, fifo_level=0, overflow=0, frame_count=0. A subsequent pixel is written normally.
- WIDTH=4, HEIGHT=2: stream 256 full frames -> frame_count returns to 0 and 256 frame_done pulses are observed.
